// File: rtl/note_decoder_pkg.sv
// Shared note codes, FSM states and the note period table for the tone decoder.
// Window bounds are computed with integer division so they match a hand calculation.
`timescale 1ns/1ps
package note_pkg;

  localparam int NUM_NOTES = 7;

  localparam logic [3:0] NOTE_DO   = 4'd0;
  localparam logic [3:0] NOTE_RE   = 4'd1;
  localparam logic [3:0] NOTE_MI   = 4'd2;
  localparam logic [3:0] NOTE_FA   = 4'd3;
  localparam logic [3:0] NOTE_SOL  = 4'd4;
  localparam logic [3:0] NOTE_LA   = 4'd5;
  localparam logic [3:0] NOTE_SI   = 4'd6;
  localparam logic [3:0] NOTE_NONE = 4'hF;

  // Note frequencies in tenths of a hertz, do..si.
  localparam int F10 [0:6] = '{2616, 2936, 3296, 3492, 3920, 4400, 4938};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_TRACK,
    ST_LOCKED
  } state_e;

  function automatic longint note_period(input longint clk_freq, input longint f10);
    return (clk_freq * 10) / f10;
  endfunction

  function automatic longint win_lo(input longint p, input longint tol_pct);
    return p - (p * tol_pct) / 100;
  endfunction

  function automatic longint win_hi(input longint p, input longint tol_pct);
    return p + (p * tol_pct) / 100;
  endfunction

endpackage

// File: rtl/note_decoder_if.sv
// Result bus between the note decoder and the score/display logic.
`timescale 1ns/1ps
interface note_decoder_if #(
  parameter int CNT_W = 22
);
  logic             listen_en;
  logic [3:0]       note_code;
  logic             note_valid;
  logic             note_start;
  logic             note_end;
  logic [CNT_W-1:0] period_out;

  modport master (
    input  listen_en,
    output note_code, note_valid, note_start, note_end, period_out
  );

  modport slave (
    output listen_en,
    input  note_code, note_valid, note_start, note_end, period_out
  );
endinterface

// File: rtl/note_decoder_meter.sv
// Synchronizes the tone line, detects rising edges and measures the period between them.
// The counter saturates, so a silent line keeps timeout asserted until the next edge.
`timescale 1ns/1ps
module tone_period_meter #(
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int CNT_W       = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tone_in,
  input  logic             clear,
  output logic             rise,
  output logic [CNT_W-1:0] period,
  output logic             timeout,
  output logic [CNT_W-1:0] period_out
);

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

  logic [1:0]       sync_q, sync_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_out_q, period_out_d;

  always_comb begin
    sync_d       = {sync_q[0], tone_in};
    prev_d       = sync_q[1];
    rise         = sync_q[1] & ~prev_q;
    period       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    timeout      = (cnt_q >= TIMEOUT_V);
    cnt_d        = cnt_q;
    period_out_d = period_out_q;
    if (clear) begin
      cnt_d        = '0;
      period_out_d = '0;
    end else if (rise) begin
      cnt_d        = '0;
      period_out_d = period;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      prev_q       <= 1'b0;
      cnt_q        <= '0;
      period_out_q <= '0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      period_out_q <= period_out_d;
    end
  end

  assign period_out = period_out_q;

endmodule

// File: rtl/note_decoder.sv
// Classifies each measured tone period into do..si and locks a note after
// CONFIRM_CNT consecutive matching periods, with start/end pulses on lock changes.
`timescale 1ns/1ps
module note_decoder
  import note_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int TOL_PCT     = 2,
  parameter int CONFIRM_CNT = 4,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int CNT_W       = 22
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tone_in,
  note_decoder_if.master bus
);

  localparam logic [3:0] CONFIRM_V = 4'(CONFIRM_CNT);

  logic             rise;
  logic             timeout;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] period_out;
  logic [3:0]       code;

  state_e     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] match_q, match_d;
  logic [3:0] note_code_q, note_code_d;
  logic       note_valid_q, note_valid_d;
  logic       note_start_q, note_start_d;
  logic       note_end_q, note_end_d;
  logic [3:0] match_new;

  tone_period_meter #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_meter (
    .clk       (clk),
    .rst_n     (rst_n),
    .tone_in   (tone_in),
    .clear     (~bus.listen_en),
    .rise      (rise),
    .period    (period),
    .timeout   (timeout),
    .period_out(period_out)
  );

  // Scanned from si down to do so that the lowest matching index wins.
  function automatic logic [3:0] classify(input logic [CNT_W-1:0] p);
    logic [3:0] res;
    longint     nom;
    res = NOTE_NONE;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      nom = note_period(longint'(CLK_FREQ), longint'(F10[i]));
      if (longint'(p) >= win_lo(nom, longint'(TOL_PCT)) &&
          longint'(p) <= win_hi(nom, longint'(TOL_PCT)))
        res = i[3:0];
    end
    return res;
  endfunction

  assign code = classify(period);

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    match_d      = match_q;
    note_code_d  = note_code_q;
    note_valid_d = note_valid_q;
    note_start_d = 1'b0;
    note_end_d   = 1'b0;
    match_new    = 4'd1;
    if (!bus.listen_en || (timeout && state_q != ST_IDLE)) begin
      note_end_d   = (state_q == ST_LOCKED);
      state_d      = ST_IDLE;
      cand_d       = NOTE_NONE;
      match_d      = '0;
      note_code_d  = NOTE_NONE;
      note_valid_d = 1'b0;
    end else if (rise) begin
      case (state_q)
        ST_IDLE: state_d = ST_ARMED;
        ST_ARMED, ST_TRACK: begin
          if (code == NOTE_NONE) begin
            state_d = ST_ARMED;
            cand_d  = NOTE_NONE;
            match_d = '0;
          end else begin
            match_new = (code == cand_q) ? match_q + 4'd1 : 4'd1;
            cand_d    = code;
            if (match_new >= CONFIRM_V) begin
              state_d      = ST_LOCKED;
              match_d      = '0;
              note_code_d  = code;
              note_valid_d = 1'b1;
              note_start_d = 1'b1;
            end else begin
              state_d = ST_TRACK;
              match_d = match_new;
            end
          end
        end
        ST_LOCKED: begin
          if (code != note_code_q) begin
            note_end_d   = 1'b1;
            note_valid_d = 1'b0;
            note_code_d  = NOTE_NONE;
            cand_d       = code;
            state_d      = (code == NOTE_NONE) ? ST_ARMED : ST_TRACK;
            match_d      = (code == NOTE_NONE) ? 4'd0 : 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cand_q       <= NOTE_NONE;
      match_q      <= '0;
      note_code_q  <= NOTE_NONE;
      note_valid_q <= 1'b0;
      note_start_q <= 1'b0;
      note_end_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      match_q      <= match_d;
      note_code_q  <= note_code_d;
      note_valid_q <= note_valid_d;
      note_start_q <= note_start_d;
      note_end_q   <= note_end_d;
    end
  end

  assign bus.note_code  = note_code_q;
  assign bus.note_valid = note_valid_q;
  assign bus.note_start = note_start_q;
  assign bus.note_end   = note_end_q;
  assign bus.period_out = period_out;

endmodule

// File: tb/tb_note_decoder.sv
// Directed bench for note_decoder, run with a scaled-down clock so note periods are a few hundred cycles.
// Scaled nominal periods: do 382, re 340, mi 303 [297..309], fa 286, sol 255, la 227, si 202.
`timescale 1ns/1ps
module tb_note_decoder;
  import note_pkg::*;

  localparam int CLK_FREQ    = 100_000;
  localparam int TOL_PCT     = 2;
  localparam int CONFIRM_CNT = 4;
  localparam int TIMEOUT_CYC = 2000;
  localparam int CNT_W       = 12;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic tone_in = 1'b0;

  note_decoder_if #(.CNT_W(CNT_W)) bus_if ();

  note_decoder #(
    .CLK_FREQ   (CLK_FREQ),
    .TOL_PCT    (TOL_PCT),
    .CONFIRM_CNT(CONFIRM_CNT),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tone_in(tone_in),
    .bus    (bus_if.master)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         rise_cyc[$];
  int         start_cnt = 0;
  int         end_cnt = 0;
  int         both_cnt = 0;
  int         last_start_cyc = 0;
  int         last_end_cyc = 0;
  logic [3:0] last_start_code = 4'hF;
  int         s0, e0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_if.note_start) begin
      start_cnt       <= start_cnt + 1;
      last_start_cyc  <= cyc;
      last_start_code <= bus_if.note_code;
    end
    if (bus_if.note_end) begin
      end_cnt      <= end_cnt + 1;
      last_end_cyc <= cyc;
    end
    if (bus_if.note_start && bus_if.note_end) both_cnt <= both_cnt + 1;
  end

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Each period starts with a rise driven 1 ns after a clock edge; rise spacing is exactly 'period'.
  task automatic applyStimulus(input int period, input int n);
    for (int k = 0; k < n; k++) begin
      tone_in = 1'b1;
      rise_cyc.push_back(cyc);
      repeat (period / 2) @(posedge clk);
      #1;
      tone_in = 1'b0;
      repeat (period - period / 2) @(posedge clk);
      #1;
    end
  endtask

  task automatic quiesce();
    bus_if.listen_en = 1'b0;
    idle(4);
    bus_if.listen_en = 1'b1;
    idle(4);
    rise_cyc.delete();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "[TB] simulation time limit reached");
  end

  // A pulse caused by a rise driven at cycle c shows up at cycle c+3 (two sync stages, one output register).
  initial begin
    bus_if.listen_en = 1'b1;
    idle(3);
    checkOutput("reset_code", longint'(bus_if.note_code), 15);
    checkOutput("reset_valid", longint'(bus_if.note_valid), 0);
    checkOutput("reset_period", longint'(bus_if.period_out), 0);
    rst_n = 1'b1;
    idle(3);

    $display("[TB] la lock");
    s0 = start_cnt;
    applyStimulus(227, 6);
    checkOutput("la_starts", longint'(start_cnt - s0), 1);
    checkOutput("la_start_cyc", longint'(last_start_cyc), longint'(rise_cyc[4] + 3));
    checkOutput("la_start_code", longint'(last_start_code), 5);
    checkOutput("la_code", longint'(bus_if.note_code), 5);
    checkOutput("la_valid", longint'(bus_if.note_valid), 1);
    checkOutput("la_period", longint'(bus_if.period_out), 227);

    $display("[TB] listen_en low while locked");
    s0 = start_cnt;
    e0 = end_cnt;
    bus_if.listen_en = 1'b0;
    idle(2);
    checkOutput("listen_end", longint'(end_cnt - e0), 1);
    checkOutput("listen_code", longint'(bus_if.note_code), 15);
    applyStimulus(227, 6);
    checkOutput("listen_no_start", longint'(start_cnt - s0), 0);
    checkOutput("listen_valid", longint'(bus_if.note_valid), 0);
    checkOutput("listen_single_end", longint'(end_cnt - e0), 1);
    bus_if.listen_en = 1'b1;
    idle(4);
    rise_cyc.delete();

    $display("[TB] do then re");
    s0 = start_cnt;
    e0 = end_cnt;
    applyStimulus(382, 6);
    checkOutput("do_code", longint'(bus_if.note_code), 0);
    checkOutput("do_valid", longint'(bus_if.note_valid), 1);
    applyStimulus(340, 5);
    checkOutput("dore_starts", longint'(start_cnt - s0), 2);
    checkOutput("dore_ends", longint'(end_cnt - e0), 1);
    checkOutput("dore_end_cyc", longint'(last_end_cyc), longint'(rise_cyc[7] + 3));
    checkOutput("re_start_cyc", longint'(last_start_cyc), longint'(rise_cyc[10] + 3));
    checkOutput("re_code", longint'(bus_if.note_code), 1);
    checkOutput("re_period", longint'(bus_if.period_out), 340);
    quiesce();

    $display("[TB] out-of-window period");
    s0 = start_cnt;
    applyStimulus(315, 8);
    checkOutput("oow_starts", longint'(start_cnt - s0), 0);
    checkOutput("oow_valid", longint'(bus_if.note_valid), 0);
    checkOutput("oow_code", longint'(bus_if.note_code), 15);
    checkOutput("oow_period", longint'(bus_if.period_out), 315);
    quiesce();

    $display("[TB] mi lower bound");
    e0 = end_cnt;
    applyStimulus(297, 5);
    checkOutput("mi_lo_code", longint'(bus_if.note_code), 2);
    applyStimulus(296, 1);
    applyStimulus(250, 1);
    checkOutput("mi_lo_out_end", longint'(end_cnt - e0), 1);
    checkOutput("mi_lo_out_cyc", longint'(last_end_cyc), longint'(rise_cyc[6] + 3));
    checkOutput("mi_lo_out_code", longint'(bus_if.note_code), 15);
    checkOutput("mi_lo_out_period", longint'(bus_if.period_out), 296);
    quiesce();

    $display("[TB] mi upper bound");
    e0 = end_cnt;
    applyStimulus(309, 5);
    checkOutput("mi_hi_code", longint'(bus_if.note_code), 2);
    applyStimulus(310, 1);
    applyStimulus(250, 1);
    checkOutput("mi_hi_out_end", longint'(end_cnt - e0), 1);
    checkOutput("mi_hi_out_valid", longint'(bus_if.note_valid), 0);
    quiesce();

    $display("[TB] sol timeout");
    e0 = end_cnt;
    applyStimulus(255, 5);
    checkOutput("sol_code", longint'(bus_if.note_code), 4);
    for (int k = 0; k < TIMEOUT_CYC + 100 && end_cnt == e0; k++) @(posedge clk);
    idle(2);
    checkOutput("to_end", longint'(end_cnt - e0), 1);
    checkOutput("to_end_cyc", longint'(last_end_cyc), longint'(rise_cyc[4] + TIMEOUT_CYC + 4));
    checkOutput("to_code", longint'(bus_if.note_code), 15);
    checkOutput("to_valid", longint'(bus_if.note_valid), 0);
    checkOutput("to_state", longint'(dut.state_q), longint'(ST_IDLE));
    rise_cyc.delete();

    $display("[TB] reset while locked");
    applyStimulus(227, 5);
    checkOutput("pre_rst_valid", longint'(bus_if.note_valid), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_code", longint'(bus_if.note_code), 15);
    checkOutput("rst_valid", longint'(bus_if.note_valid), 0);
    checkOutput("rst_period", longint'(bus_if.period_out), 0);
    checkOutput("rst_pulses", longint'({bus_if.note_start, bus_if.note_end}), 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    rise_cyc.delete();
    applyStimulus(227, 4);
    checkOutput("rearm_not_yet", longint'(bus_if.note_valid), 0);
    applyStimulus(227, 1);
    checkOutput("rearm_valid", longint'(bus_if.note_valid), 1);
    checkOutput("rearm_start_cyc", longint'(last_start_cyc), longint'(rise_cyc[4] + 3));

    checkOutput("start_end_overlap", longint'(both_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
